i2c_reg_master: RTL and testbench

Parametrised I2C controller that performs complete register-addressed transactions of up to `MAX_BYTES` data bytes. A write sends device address, register pointer and data. A read sends device address and register pointer, issues a repeated START, then reads the data. Target ACK/NACK is checked on every byte. The block sits between the sensor/display drivers and the board-level SCL/SDA pins, and replaces single-byte raw transfers with one-handshake register accesses.

---
 rtl/i2c_reg_master.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_reg_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_master.sv
// Register-addressed I2C master: START, device address, register pointer, then N write bytes or a repeated START and N reads.
// Define I2C_CLOCK_STRETCH_EN for open-drain SCL with target clock stretching; otherwise SCL is push-pull and never sampled.
module i2c_reg_master #(
  parameter int CLK_HZ          = 12_000_000,
  parameter int I2C_CLK_HZ      = 400_000,
  parameter int MAX_BYTES       = 4,
  parameter int COOLDOWN_CYCLES = 120,
  localparam int LEN_W          = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire                    scl,
  inout  wire                    sda,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_rw,
  input  logic [6:0]             i_addr,
  input  logic [7:0]             i_reg,
  input  logic [LEN_W-1:0]       i_len,
  input  logic [8*MAX_BYTES-1:0] i_data,
  output logic                   o_valid,
  output logic                   o_nack,
  output logic [8*MAX_BYTES-1:0] o_data,
  output logic                   o_busy
);

  localparam int DIV    = CLK_HZ / I2C_CLK_HZ / 2;
  localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_WDATA,
    RSTART, RADDR, ACK_RADDR, RDATA, MACK, STOP, COOLDOWN
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             phase_q, phase_d;
  logic [2:0]             bit_q, bit_d;
  logic [LEN_W-1:0]       byte_q, byte_d, n_q, n_d;
  logic [7:0]             shreg_q, shreg_d, rx_q, rx_d, reg_q, reg_d;
  logic                   rw_q, rw_d, valid_q, valid_d, nack_q, nack_d;
  logic                   scl_q, scl_d, sda_q, sda_d;
  logic [6:0]             addr_q, addr_d;
  logic [8*MAX_BYTES-1:0] wdata_q, wdata_d, odata_q, odata_d;
  logic [COOL_W-1:0]      cool_q, cool_d;
  logic                   hold, tick, load, goStop, lastByte;
  logic [7:0]             loadByte, rxByte;

`ifdef I2C_CLOCK_STRETCH_EN
  assign scl  = scl_q ? 1'bz : 1'b0;
  // Freeze the first cycle of a high half while the target still holds SCL low.
  assign hold = scl_q && (cnt_q == '0) && !scl && (state_q != IDLE) && (state_q != COOLDOWN);
`else
  assign scl  = scl_q;
  assign hold = 1'b0;
`endif
  assign sda  = sda_q ? 1'bz : 1'b0;
  assign tick = !hold && (cnt_q == CW'(DIV - 1));

  assign i_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_valid = valid_q;
  assign o_nack  = nack_q;
  assign o_data  = odata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;    cnt_q   <= '0;   phase_q <= '0;   bit_q   <= '0;
      byte_q  <= '0;      n_q     <= '0;   shreg_q <= '1;   rx_q    <= '0;
      reg_q   <= '0;      rw_q    <= 1'b0; valid_q <= 1'b0; nack_q  <= 1'b0;
      scl_q   <= 1'b1;    sda_q   <= 1'b1; addr_q  <= '0;   wdata_q <= '0;
      odata_q <= '0;      cool_q  <= '0;
    end else begin
      state_q <= state_d; cnt_q   <= cnt_d;   phase_q <= phase_d; bit_q   <= bit_d;
      byte_q  <= byte_d;  n_q     <= n_d;     shreg_q <= shreg_d; rx_q    <= rx_d;
      reg_q   <= reg_d;   rw_q    <= rw_d;    valid_q <= valid_d; nack_q  <= nack_d;
      scl_q   <= scl_d;   sda_q   <= sda_d;   addr_q  <= addr_d;  wdata_q <= wdata_d;
      odata_q <= odata_d; cool_q  <= cool_d;
    end
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; phase_d = phase_q; bit_d = bit_q;
    byte_d = byte_q; n_d = n_q; shreg_d = shreg_q; rx_d = rx_q; reg_d = reg_q;
    rw_d = rw_q; valid_d = valid_q; nack_d = nack_q; scl_d = scl_q; sda_d = sda_q;
    addr_d = addr_q; wdata_d = wdata_q; odata_d = odata_q; cool_d = cool_q;
    load = 1'b0; loadByte = 8'hFF; goStop = 1'b0;
    lastByte = ((byte_q + LEN_W'(1)) == n_q);
    rxByte = {rx_q[6:0], sda};
    if (!hold) cnt_d = tick ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_valid) begin
          state_d = START; scl_d = 1'b1; sda_d = 1'b0;
          valid_d = 1'b0; nack_d = 1'b0; odata_d = '0;
          rw_d = i_rw; addr_d = i_addr; reg_d = i_reg; wdata_d = i_data;
          n_d = (i_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : i_len;
          if (i_rw && (n_d == '0)) n_d = LEN_W'(1);
        end
      end
      START: if (tick) begin
        load = 1'b1; loadByte = {addr_q, 1'b0}; state_d = ADDR;
      end
      ADDR, REG, WDATA, RADDR, RDATA: if (tick) begin
        if (phase_q == 2'd0) begin
          scl_d = 1'b1; phase_d = 2'd1;
        end else begin
          scl_d = 1'b0; phase_d = 2'd0; rx_d = rxByte;
          if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1; sda_d = shreg_q[7]; shreg_d = {shreg_q[6:0], 1'b1};
          end else begin
            sda_d = 1'b1;
            case (state_q)
              ADDR:    state_d = ACK_ADDR;
              REG:     state_d = ACK_REG;
              WDATA:   state_d = ACK_WDATA;
              RADDR:   state_d = ACK_RADDR;
              default: begin
                for (int k = 0; k < MAX_BYTES; k++)
                  if (byte_q == LEN_W'(k)) odata_d[8*k +: 8] = rxByte;
                // Master ACKs every byte except the last, which it NACKs.
                sda_d = lastByte; state_d = MACK;
              end
            endcase
          end
        end
      end
      ACK_ADDR, ACK_REG, ACK_WDATA, ACK_RADDR: if (tick) begin
        if (phase_q == 2'd0) begin
          scl_d = 1'b1; phase_d = 2'd1;
        end else if (sda) begin
          nack_d = 1'b1; goStop = 1'b1;
        end else begin
          case (state_q)
            ACK_ADDR: begin load = 1'b1; loadByte = reg_q; state_d = REG; end
            ACK_REG: begin
              if (rw_q) begin
                state_d = RSTART; scl_d = 1'b0; sda_d = 1'b1; phase_d = 2'd0;
              end else if (n_q == '0) begin
                goStop = 1'b1;
              end else begin
                load = 1'b1; loadByte = wdata_q[7:0]; wdata_d = wdata_q >> 8;
                byte_d = '0; state_d = WDATA;
              end
            end
            ACK_WDATA: begin
              if (lastByte) goStop = 1'b1;
              else begin
                load = 1'b1; loadByte = wdata_q[7:0]; wdata_d = wdata_q >> 8;
                byte_d = byte_q + LEN_W'(1); state_d = WDATA;
              end
            end
            default: begin load = 1'b1; byte_d = '0; state_d = RDATA; end
          endcase
        end
      end
      MACK: if (tick) begin
        if (phase_q == 2'd0) begin
          scl_d = 1'b1; phase_d = 2'd1;
        end else if (lastByte) begin
          goStop = 1'b1;
        end else begin
          load = 1'b1; byte_d = byte_q + LEN_W'(1); state_d = RDATA;
        end
      end
      RSTART: if (tick) begin
        if (phase_q == 2'd0) begin
          scl_d = 1'b1; phase_d = 2'd1;
        end else if (phase_q == 2'd1) begin
          sda_d = 1'b0; phase_d = 2'd2;
        end else begin
          load = 1'b1; loadByte = {addr_q, 1'b1}; state_d = RADDR;
        end
      end
      STOP: if (tick) begin
        if (phase_q == 2'd0) begin
          scl_d = 1'b1; phase_d = 2'd1;
        end else begin
          sda_d = 1'b1; valid_d = 1'b1; cool_d = '0; state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        cool_d = cool_q + COOL_W'(1);
        if (cool_q == COOL_W'(COOLDOWN_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      scl_d = 1'b0; sda_d = loadByte[7]; shreg_d = {loadByte[6:0], 1'b1};
      bit_d = 3'd7; phase_d = 2'd0;
    end
    if (goStop) begin
      state_d = STOP; scl_d = 1'b0; sda_d = 1'b0; phase_d = 2'd0;
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Self-checking bench for i2c_reg_master: behavioural I2C target plus a scoreboard of expected completions.
// With I2C_CLOCK_STRETCH_EN defined it also exercises target clock stretching.
module tb_i2c_reg_master;

  localparam int MAX_BYTES = 4;
  localparam int DIV       = 15;
  localparam int COOL      = 120;

  typedef struct {
    int          lat;
    logic        nack;
    logic [31:0] data;
    int          starts;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_valid = 1'b0, i_rw = 1'b0;
  logic [6:0]  i_addr = '0;
  logic [7:0]  i_reg = '0;
  logic [2:0]  i_len = '0;
  logic [31:0] i_data = '0;
  logic        i_ready, o_valid, o_nack, o_busy;
  logic [31:0] o_data;
  wire         scl, sda;
  logic        tbSdaLow = 1'b0;

  assign sda = tbSdaLow ? 1'b0 : 1'bz;
  pullup (sda);
`ifdef I2C_CLOCK_STRETCH_EN
  logic tbSclLow = 1'b0;
  assign scl = tbSclLow ? 1'b0 : 1'bz;
  pullup (scl);
`endif

  i2c_reg_master #(.CLK_HZ(12_000_000), .I2C_CLK_HZ(400_000), .MAX_BYTES(MAX_BYTES),
                   .COOLDOWN_CYCLES(COOL)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .i_valid(i_valid), .i_ready(i_ready),
    .i_rw(i_rw), .i_addr(i_addr), .i_reg(i_reg), .i_len(i_len), .i_data(i_data),
    .o_valid(o_valid), .o_nack(o_nack), .o_data(o_data), .o_busy(o_busy));

  initial forever #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int assertCount = 0, failCount = 0;
  int acceptCycle, startBase, stopBase;
  exp_t expQ[$];
  logic [7:0] expWire[$], wireBytes[$];
  logic expAcks[$], masterAcks[$];

  // Behavioural target, sampling the bus on the falling clk edge.
  logic [6:0] respAddr = 7'h3C;
  logic [7:0] readData [4];
  logic       prevScl = 1'b1, prevSda = 1'b1, rxMode = 1'b1, afterAck = 1'b0;
  logic       addrMatch = 1'b0, readDir = 1'b0, lastMasterAck = 1'b0;
  logic [7:0] shreg = '0, txByte = '0;
  int         bitCnt = 0, byteIdx = 0, txIdx = 0, startCnt = 0, stopCnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      tbSdaLow = 1'b0; bitCnt = 0; afterAck = 1'b0; rxMode = 1'b1; byteIdx = 0;
      prevScl = 1'b1; prevSda = 1'b1;
    end else begin
      if (prevScl && scl && prevSda && !sda) begin
        startCnt++; bitCnt = 0; afterAck = 1'b0; rxMode = 1'b1; byteIdx = 0; tbSdaLow = 1'b0;
      end else if (prevScl && scl && !prevSda && sda) begin
        stopCnt++; tbSdaLow = 1'b0;
      end else if (!prevScl && scl) begin
        if (bitCnt < 8) begin
          shreg = {shreg[6:0], sda}; bitCnt++;
        end else begin
          if (!rxMode) masterAcks.push_back(sda);
          lastMasterAck = sda; bitCnt = 0; afterAck = 1'b1;
        end
      end else if (prevScl && !scl) begin
        if (bitCnt == 8) begin
          if (rxMode) begin
            wireBytes.push_back(shreg);
            if (byteIdx == 0) begin addrMatch = (shreg[7:1] == respAddr); readDir = shreg[0]; end
            tbSdaLow = addrMatch;
          end else tbSdaLow = 1'b0;
          byteIdx++;
        end else if (afterAck) begin
          afterAck = 1'b0; tbSdaLow = 1'b0;
          if (rxMode && readDir && addrMatch && byteIdx == 1) begin
            rxMode = 1'b0; txIdx = 0; txByte = readData[0]; tbSdaLow = !txByte[7];
          end else if (!rxMode && !lastMasterAck && txIdx < 3) begin
            txIdx++; txByte = readData[txIdx]; tbSdaLow = !txByte[7];
          end
        end else if (!rxMode && bitCnt >= 1 && bitCnt <= 7) begin
          tbSdaLow = !txByte[7 - bitCnt];
        end
      end
      prevScl = scl; prevSda = sda;
    end
  end

  function automatic int wrLat(input int n);
    return (1 + 18 * (2 + n) + 2) * DIV;
  endfunction

  function automatic int rdLat(input int n);
    return (1 + 36 + 3 + 18 * (1 + n) + 2) * DIV;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] rg,
                               input logic [2:0] len, input logic [31:0] data,
                               input int expLat, input logic expNack, input logic [31:0] expData,
                               input int expStarts);
    exp_t e;
    @(negedge clk);
    checkOutput("readyBeforeAccept", i_ready, 1'b1);
    i_valid = 1'b1; i_rw = rw; i_addr = addr; i_reg = rg; i_len = len; i_data = data;
    e.lat = expLat; e.nack = expNack; e.data = expData; e.starts = expStarts;
    expQ.push_back(e);
    startBase = startCnt; stopBase = stopCnt;
    @(posedge clk); #1;
    acceptCycle = cycle;
    i_valid = 1'b0; i_data = '1; i_len = '1;
    checkOutput("acceptReadyLow", i_ready, 1'b0);
    checkOutput("acceptBusy", o_busy, 1'b1);
    checkOutput("acceptValidClear", o_valid, 1'b0);
    checkOutput("acceptDataZero", o_data, 32'h0);
  endtask

  task automatic waitResult(input string tag);
    int waited = 0, coolWait = 0;
    exp_t e;
    while (o_valid !== 1'b1 && waited < 5000) begin @(posedge clk); #1; waited++; end
    checkOutput({tag, "Done"}, o_valid, 1'b1);
    e = expQ.pop_front();
    checkOutput({tag, "Latency"}, cycle - acceptCycle, e.lat);
    checkOutput({tag, "Nack"}, o_nack, e.nack);
    checkOutput({tag, "Data"}, o_data, e.data);
    while (i_ready !== 1'b1 && coolWait < 1000) begin @(posedge clk); #1; coolWait++; end
    checkOutput({tag, "Cooldown"}, coolWait, COOL);
    checkOutput({tag, "ValidSticky"}, o_valid, 1'b1);
    checkOutput({tag, "Starts"}, startCnt - startBase, e.starts);
    checkOutput({tag, "Stops"}, stopCnt - stopBase, 1);
    checkOutput({tag, "WireCount"}, wireBytes.size(), expWire.size());
    while (expWire.size() > 0 && wireBytes.size() > 0)
      checkOutput({tag, "WireByte"}, wireBytes.pop_front(), expWire.pop_front());
    checkOutput({tag, "AckCount"}, masterAcks.size(), expAcks.size());
    while (expAcks.size() > 0 && masterAcks.size() > 0)
      checkOutput({tag, "MasterAck"}, masterAcks.pop_front(), expAcks.pop_front());
    wireBytes.delete(); expWire.delete(); masterAcks.delete(); expAcks.delete();
  endtask

  initial begin
    readData = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetScl", scl, 1'b1);
    checkOutput("resetSda", sda, 1'b1);
    checkOutput("resetReady", i_ready, 1'b1);
    checkOutput("resetValid", o_valid, 1'b0);
    checkOutput("resetNack", o_nack, 1'b0);
    checkOutput("resetBusy", o_busy, 1'b0);
    checkOutput("resetData", o_data, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] two-byte write");
    respAddr = 7'h3C;
    expWire = '{8'h78, 8'h10, 8'hA5, 8'h5A};
    applyStimulus(1'b0, 7'h3C, 8'h10, 3'd2, 32'h0000_5AA5, wrLat(2), 1'b0, 32'h0, 1);
    waitResult("wr2");

    $display("[TB] three-byte read");
    respAddr = 7'h68;
    expWire = '{8'hD0, 8'h75, 8'hD1};
    expAcks = '{1'b0, 1'b0, 1'b1};
    applyStimulus(1'b1, 7'h68, 8'h75, 3'd3, 32'h0, rdLat(3), 1'b0, 32'h0033_2211, 2);
    waitResult("rd3");

    $display("[TB] write to absent target");
    respAddr = 7'h3C;
    expWire = '{8'hA0};
    applyStimulus(1'b0, 7'h50, 8'h01, 3'd1, 32'h0000_00FF, (1 + 18 + 2) * DIV, 1'b1, 32'h0, 1);
    waitResult("nackAddr");

    $display("[TB] zero-length read");
    respAddr = 7'h68;
    readData = '{8'h9C, 8'h22, 8'h33, 8'h44};
    expWire = '{8'hD0, 8'h00, 8'hD1};
    expAcks = '{1'b1};
    applyStimulus(1'b1, 7'h68, 8'h00, 3'd0, 32'h0, rdLat(1), 1'b0, 32'h0000_009C, 2);
    waitResult("rd0");

    $display("[TB] pointer-only and oversized writes");
    respAddr = 7'h3C;
    expWire = '{8'h78, 8'h05};
    applyStimulus(1'b0, 7'h3C, 8'h05, 3'd0, 32'h1234_5678, wrLat(0), 1'b0, 32'h0, 1);
    waitResult("wr0");
    expWire = '{8'h78, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(1'b0, 7'h3C, 8'h20, 3'd7, 32'hDEAD_BEEF, wrLat(4), 1'b0, 32'h0, 1);
    waitResult("wrClamp");

    $display("[TB] reset during write data");
    applyStimulus(1'b0, 7'h3C, 8'h10, 3'd2, 32'h0000_5AA5, wrLat(2), 1'b0, 32'h0, 1);
    repeat (41 * DIV) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortScl", scl, 1'b1);
    checkOutput("abortSda", sda, 1'b1);
    checkOutput("abortReady", i_ready, 1'b1);
    checkOutput("abortBusy", o_busy, 1'b0);
    checkOutput("abortValid", o_valid, 1'b0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    void'(expQ.pop_front());
    wireBytes.delete(); expWire.delete(); masterAcks.delete(); expAcks.delete();
    expWire = '{8'h78, 8'h11, 8'h4B};
    applyStimulus(1'b0, 7'h3C, 8'h11, 3'd1, 32'h0000_004B, wrLat(1), 1'b0, 32'h0, 1);
    waitResult("afterAbort");

`ifdef I2C_CLOCK_STRETCH_EN
    $display("[TB] target stretches the first register bit");
    expWire = '{8'h78, 8'h10, 8'hA5, 8'h5A};
    applyStimulus(1'b0, 7'h3C, 8'h10, 3'd2, 32'h0000_5AA5, wrLat(2) + 100, 1'b0, 32'h0, 1);
    for (int w = 0; w < 2000 && cycle < acceptCycle + 19 * DIV + 5; w++) begin @(posedge clk); #1; end
    @(negedge clk); tbSclLow = 1'b1;
    for (int w = 0; w < 2000 && cycle < acceptCycle + 20 * DIV + 100; w++) begin @(posedge clk); #1; end
    @(negedge clk); tbSclLow = 1'b0;
    waitResult("stretch");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
